// File: rtl/mips_pkg.sv
// Shared constants, field positions and small helpers for the MIPS core pipeline.
package mips_pkg;

    localparam logic [1:0]  PC_SEL_SEQ       = 2'd0;
    localparam logic [1:0]  PC_SEL_BR        = 2'd1;
    localparam logic [1:0]  PC_SEL_J         = 2'd2;
    localparam logic [1:0]  PC_SEL_JR        = 2'd3;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int IDX_MSB   = 25;
    localparam int IDX_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pc_target_gen.sv
// Combinational redirect target for branch, jump and jump-register.
module pc_target_gen
    import mips_pkg::*;
(
    input  logic [1:0]  pc_sel_i,
    input  logic [25:0] instr_idx_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] target_o
);

    logic [15:0] imm_s;
    logic [31:0] raw_s;

    assign imm_s = instr_idx_i[IMM_MSB:IMM_LSB];

    always_comb begin
        raw_s = pc_plus4_i;
        case (pc_sel_i)
            PC_SEL_BR: raw_s = pc_plus4_i + {{14{imm_s[15]}}, imm_s, 2'b00};
            PC_SEL_J:  raw_s = {pc_plus4_i[31:28], instr_idx_i, 2'b00};
            PC_SEL_JR: raw_s = jr_target_i;
            default:   raw_s = pc_plus4_i;
        endcase
    end

    assign target_o = align_word(raw_s);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with one-word stall buffer and IF/ID register.
// Optional feature: DELAY_SLOT_EN keeps the instruction after a taken redirect.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 stall_i,
    input  logic [1:0]           pc_sel_i,
    input  logic [31:0]          jr_target_i,
    output logic                 id_valid_o,
    output logic [31:0]          id_instr_o,
    output logic [31:0]          id_pc_plus4_o,
    output logic [5:0]           id_op_o,
    output logic [5:0]           id_funct_o,
    output logic                 id_is_nop_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;
    logic         buf_valid_q, buf_valid_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [31:0]  buf_pc4_q, buf_pc4_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [31:0]  id_pc4_q, id_pc4_d;
`ifdef DELAY_SLOT_EN
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
`endif

    logic         ack_s;
    logic         redirect_s;
    logic [31:0]  fetch_pc4_s;
    logic [31:0]  target_s;

    assign ack_s       = req_q & imem.ack;
    assign fetch_pc4_s = addr_q + 32'd4;
    assign redirect_s  = id_valid_q & ~stall_i & (pc_sel_i != PC_SEL_SEQ);

    pc_target_gen u_target (
        .pc_sel_i    (pc_sel_i),
        .instr_idx_i (id_instr_q[IDX_MSB:IDX_LSB]),
        .pc_plus4_i  (id_pc4_q),
        .jr_target_i (jr_target_i),
        .target_o    (target_s)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        id_valid_d  = id_valid_q;
        id_instr_d  = id_instr_q;
        id_pc4_d    = id_pc4_q;
`ifdef DELAY_SLOT_EN
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
`endif

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // IF/ID takes the buffered word first, otherwise the word acked this cycle.
                if (!stall_i) begin
                    if (buf_valid_q) begin
                        id_valid_d  = 1'b1;
                        id_instr_d  = buf_instr_q;
                        id_pc4_d    = buf_pc4_q;
                        buf_valid_d = 1'b0;
                    end else if (ack_s) begin
                        id_valid_d = 1'b1;
                        id_instr_d = imem.rdata;
                        id_pc4_d   = fetch_pc4_s;
                    end else begin
                        id_valid_d = 1'b0;
                        id_instr_d = NOP_INSTR;
                    end
                end else if (ack_s) begin
                    buf_valid_d = 1'b1;
                    buf_instr_d = imem.rdata;
                    buf_pc4_d   = fetch_pc4_s;
                end else begin
                    buf_valid_d = buf_valid_q;
                end

                if (ack_s) begin
                    pc_d = pc_q + 32'd4;
                end else begin
                    pc_d = pc_q;
                end
`ifdef DELAY_SLOT_EN
                if (ack_s && pend_valid_q) begin
                    pc_d         = pend_pc_q;
                    pend_valid_d = 1'b0;
                end else begin
                    pend_valid_d = pend_valid_q;
                end
                // Slot not yet fetched: park the target until the slot's ack moves pc.
                if (redirect_s) begin
                    if ((pc_q != id_pc4_q) || ack_s) begin
                        pc_d = target_s;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_pc_d    = target_s;
                    end
                end else begin
                    pend_pc_d = pend_pc_q;
                end
                if (!req_q || ack_s) begin
                    req_d  = ~buf_valid_d;
                    addr_d = pc_d;
                end else begin
                    req_d = req_q;
                end
`else
                if (redirect_s) begin
                    pc_d        = target_s;
                    buf_valid_d = 1'b0;
                    id_valid_d  = 1'b0;
                    id_instr_d  = NOP_INSTR;
                end else begin
                    id_pc4_d = id_pc4_d;
                end
                if (redirect_s && req_q && !ack_s) begin
                    state_d = ST_DROP;
                end else if (!req_q || ack_s) begin
                    req_d  = ~buf_valid_d;
                    addr_d = pc_d;
                end else begin
                    req_d = req_q;
                end
`endif
            end
            ST_DROP: begin
                if (!stall_i) begin
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                end else begin
                    id_valid_d = id_valid_q;
                end
                // Stale word is thrown away; relaunch straight at the redirect target.
                if (ack_s) begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_instr_q <= 32'h0000_0000;
            buf_pc4_q   <= 32'h0000_0000;
            id_valid_q  <= 1'b0;
            id_instr_q  <= 32'h0000_0000;
            id_pc4_q    <= 32'h0000_0000;
`ifdef DELAY_SLOT_EN
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0000_0000;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            id_valid_q  <= id_valid_d;
            id_instr_q  <= id_instr_d;
            id_pc4_q    <= id_pc4_d;
`ifdef DELAY_SLOT_EN
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
`endif
        end
    end

    assign imem.req      = req_q;
    assign imem.addr     = addr_q;
    assign id_valid_o    = id_valid_q;
    assign id_instr_o    = id_instr_q;
    assign id_pc_plus4_o = id_pc4_q;
    assign id_op_o       = id_instr_q[OP_MSB:OP_LSB];
    assign id_funct_o    = id_instr_q[FUNCT_MSB:FUNCT_LSB];
    assign id_is_nop_o   = ~id_valid_q | (id_instr_q == NOP_INSTR);

endmodule
